// File: rtl/mul_seq_if.sv
// mul_seq request/response bundle.
// master drives operands and start; slave returns status and product.
interface mul_seq_if #(
  parameter int WIDTH = 8
);
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (
    output start, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, a, b,
    output busy, done, product
  );
endinterface

// File: rtl/mul_seq.sv
// Sequential shift-add unsigned multiplier, one bit per cycle.
// All accumulation goes through one shared carry-lookahead adder.
module cla_add #(
  parameter int N = 16
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);
  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N:0]   c;

  assign g = x & y;
  assign p = x ^ y;

  // each carry is a flat generate/propagate term, no ripple chain
  always_comb begin
    logic t;
    logic pp;
    c = '0;
    c[0] = cin;
    for (int i = 0; i < N; i++) begin
      t  = g[i];
      pp = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        t  = t | (pp & g[j]);
        pp = pp & p[j];
      end
      c[i+1] = t | (pp & cin);
    end
  end

  assign sum  = p ^ c[N-1:0];
  assign cout = c[N];
endmodule

module mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  mul_seq_if.slave bus
);
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [PW-1:0]   mcand;
  logic [PW-1:0]   acc;
  logic [PW-1:0]   sum;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]   cnt;
  logic            unused_cout;

  cla_add #(
    .N(PW)
  ) u_add (
    .x   (acc),
    .y   (mcand),
    .cin (1'b0),
    .sum (sum),
    .cout(unused_cout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (bus.start) state_n = RUN;
      RUN:     if (cnt == LAST) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            mcand  <= {{WIDTH{1'b0}}, bus.a};
            mplier <= bus.b;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        RUN: begin
          if (mplier[0]) acc <= sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = (state != IDLE);
  assign bus.done    = (state == DONE);
  assign bus.product = acc;
endmodule

// File: tb/tb_mul_seq.sv
// Scoreboard bench for mul_seq: a*b reference, latency,
// done width, held start, async reset abort.
module tb_mul_seq;
  localparam int W = 8;

  typedef struct {
    logic [15:0] prod;
    int          acc;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   failures;
  logic prev_done;
  exp_t sb[$];
  exp_t me;

  mul_seq_if #(.WIDTH(W)) bus ();

  mul_seq #(
    .WIDTH(W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial prev_done = 1'b0;
  always @(negedge clk) begin
    if (prev_done) begin
      check("done_width", {31'b0, bus.done}, 0);
      check("busy_after", {31'b0, bus.busy}, 0);
    end
    if (bus.done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        me = sb.pop_front();
        check("product", {16'b0, bus.product}, {16'b0, me.prod});
        check("latency", cyc - me.acc, W);
      end
    end
    prev_done = bus.done;
  end

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) check("idle_timeout", 1, 0);
  endtask

  task automatic drain(input int lim);
    int n = 0;
    while (sb.size() != 0 && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("done_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic mul_op(input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    wait_idle();
    bus.a     = x;
    bus.b     = y;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    e.prod = {8'h00, x} * {8'h00, y};
    e.acc  = cyc;
    sb.push_back(e);
    check("busy_acc", {31'b0, bus.busy}, 1);
    bus.a = 8'($urandom);
    bus.b = 8'($urandom);
    drain(20);
  endtask

  initial begin
    exp_t e;
    int   t0;
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    #12;
    check("rst_busy", {31'b0, bus.busy}, 0);
    check("rst_done", {31'b0, bus.done}, 0);
    check("rst_prod", {16'b0, bus.product}, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    mul_op(8'h03, 8'h05);
    repeat (3) @(negedge clk);
    check("hold_prod", {16'b0, bus.product}, 32'h000F);
    check("hold_busy", {31'b0, bus.busy}, 0);
    mul_op(8'hFF, 8'hFF);
    mul_op(8'h00, 8'hA5);
    mul_op(8'h80, 8'h01);

    wait_idle();
    bus.a     = 8'd2;
    bus.b     = 8'd7;
    bus.start = 1'b1;
    @(negedge clk);
    t0     = cyc;
    e.prod = 16'h000E;
    e.acc  = t0;
    sb.push_back(e);
    repeat (3) @(negedge clk);
    bus.a  = 8'd9;
    e.prod = 16'h003F;
    e.acc  = t0 + W + 2;
    sb.push_back(e);
    drain(30);
    bus.start = 1'b0;

    wait_idle();
    bus.a     = 8'h12;
    bus.b     = 8'h34;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    e.prod = 16'h03A8;
    e.acc  = cyc;
    sb.push_back(e);
    repeat (4) @(negedge clk);
    check("mid_prod", {16'b0, bus.product}, 32'h0048);
    #2;
    reset = 1'b1;
    #1;
    check("arst_prod", {16'b0, bus.product}, 0);
    check("arst_busy", {31'b0, bus.busy}, 0);
    check("arst_done", {31'b0, bus.done}, 0);
    sb.delete();
    bus.start = 1'b1;
    @(negedge clk);
    check("rst_start_ign", {31'b0, bus.busy}, 0);
    bus.start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_idle", {31'b0, bus.busy}, 0);
    mul_op(8'h12, 8'h34);

    for (int i = 0; i < 2000; i++) begin
      mul_op(8'($urandom), 8'($urandom));
    end
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
